// File: rtl/pc_redirect_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_redirect_ctrl_if : instruction-fetch request/ack/abort bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_redirect_ctrl_if;
  logic        fetch_req;
  logic        fetch_ack;
  logic        flush;
  logic [31:0] pc;

  modport master (output fetch_req, output pc, output flush, input fetch_ack);
  modport slave  (input fetch_req, input pc, input flush, output fetch_ack);
endinterface
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_redirect_ctrl : owns the fetch PC; sequences exception/ERET/branch redirects
// Optional statistics counters under macro PC_REDIRECT_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_redirect_ctrl_if.master     fetch,
  input  logic                   br_valid,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  input  logic                   exc_req,
  input  logic                   eret_req,
  input  logic [31:0]            epc,
  output logic                   redirect_pending
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [CNT_W-1:0]       stat_br_taken,
  output logic [CNT_W-1:0]       stat_exc
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] pend_target, pend_nxt;
  logic        req_reg;
  logic        accept;
  logic        taken_evt;

  assign accept           = req_reg & fetch.fetch_ack;
  assign fetch.pc         = pc_reg;
  assign fetch.fetch_req  = req_reg;
  assign fetch.flush      = exc_req | eret_req;
  assign redirect_pending = (state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_reg      <= RESET_PC;
      pend_target <= 32'd0;
      req_reg     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_reg      <= pc_nxt;
      pend_target <= pend_nxt;
      req_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    pend_nxt  = pend_target;
    taken_evt = 1'b0;
    if (exc_req) begin
      state_nxt = IDLE;
      pc_nxt    = EXC_VECTOR;
      pend_nxt  = 32'd0;
    end else if (eret_req) begin
      state_nxt = IDLE;
      pc_nxt    = epc;
      pend_nxt  = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (br_valid && br_taken) begin
            taken_evt = 1'b1;
            // Ack now means the delay slot is already fetched: jump straight away.
            if (accept) begin
              pc_nxt = br_target;
            end else begin
              pend_nxt  = br_target;
              state_nxt = PEND;
            end
          end else if (accept) begin
            pc_nxt = pc_reg + 32'd4;
          end
        end
        PEND: begin
          if (accept) begin
            pc_nxt    = pend_target;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !exc_req && !eret_req && state == PEND) begin
      assert (!br_valid) else $error("branch resolved while its predecessor's delay slot is pending");
    end
  end
`endif

`ifdef PC_REDIRECT_STATS_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_taken <= '0;
      stat_exc      <= '0;
    end else begin
      if (taken_evt && stat_br_taken != '1) stat_br_taken <= stat_br_taken + ONE;
      if (exc_req && stat_exc != '1)        stat_exc      <= stat_exc + ONE;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Owns the architectural fetch PC and sequences every PC change for the 5-stage MIPS pipeline.
- Consumes the branch-control resolution from ID (taken flag + target) and honours the MIPS delay slot.
- Arbitrates redirects between exception entry, ERET return and taken branches, and handshakes with the instruction-fetch port.
- Sits between the branch-control unit / CP0 and the I-side memory interface.

Parameters:
RESET_PC  32'hBFC0_0000  PC value loaded on reset
EXC_VECTOR  32'hBFC0_0380  general exception entry address
CNT_W  32  width of statistics counters (used only with optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_req  out  1  fetch request for address pc
fetch_ack  in  1  fetch port accepted the current request
pc  out  32  current fetch address
br_valid  in  1  branch/jump resolved in ID this cycle (single-cycle pulse)
br_taken  in  1  resolved PC write (valid with br_valid)
br_target  in  32  resolved target (valid with br_valid)
exc_req  in  1  CP0 exception redirect request
eret_req  in  1  CP0 ERET redirect request
epc  in  32  ERET return address
flush  out  1  kill IF/ID contents and abort in-flight fetch
redirect_pending  out  1  taken branch waiting for its delay slot to be fetched

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, pend_target=0, fetch_req=0, flush=0, redirect_pending=0. First cycle after release: fetch_req=1 and stays 1 except as noted.
- Handshake: pc and fetch_req stay stable until fetch_ack, unless flush=1 (abort). An accepted fetch is fetch_req & fetch_ack at a rising edge.
- States: IDLE, PEND. redirect_pending = (state==PEND), registered.
- Priority per cycle: exc_req > eret_req > branch > sequential.
- exc_req=1: flush=1 (combinational, same cycle); next pc=EXC_VECTOR regardless of fetch_ack; state->IDLE; any pending target is discarded.
- eret_req=1 (no exc_req): flush=1; next pc=epc; state->IDLE. No delay slot.
- IDLE, br_valid & br_taken:
  - With fetch_ack, the delay slot is accepted now; next pc=br_target; stay IDLE.
  - Without fetch_ack, hold pc; pend_target<=br_target; ->PEND.
- IDLE, br_valid & !br_taken: sequential behaviour.
- PEND:
  - With fetch_ack, the delay slot is accepted; next pc=pend_target; ->IDLE.
  - Otherwise hold.
  - br_valid in PEND is illegal (branch in delay slot); ignored; simulation assertion fires.
- Sequential: on accepted fetch, pc<=pc+32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- flush is never asserted for branches; the delay slot always executes.
- Latency: redirect visible on pc one cycle after the deciding edge. A branch to its own delay-slot address is legal and behaves normally.
- Targets are not alignment-checked. Misaligned-PC exceptions belong to CP0.

Optional Feature:
- Macro PC_REDIRECT_STATS_EN.
- Defined: adds outputs stat_br_taken[CNT_W-1:0] and stat_exc[CNT_W-1:0].
  - stat_br_taken counts taken branches on entry to the redirect decision (IDLE & br_valid & br_taken, exc/eret absent).
  - stat_exc counts cycles with exc_req=1.
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset release with fetch_ack=1 each cycle -> pc sequence BFC00000, BFC00004, BFC00008; flush=0.
- Branch at BFC00010 resolved (br_taken=1, target 80001000) while delay slot BFC00014 acked -> next pc=80001000, redirect_pending=0.
- Same branch with fetch_ack=0 for 3 cycles -> pc holds BFC00014, redirect_pending=1; ack on 4th cycle -> pc=80001000, redirect_pending=0.
- exc_req in PEND with fetch_ack=0 -> flush=1 that cycle; next pc=BFC00380; pending target discarded.
- exc_req and eret_req together with epc=80002000 -> pc=BFC00380. eret_req alone -> pc=80002000, flush=1.
- pc=FFFFFFFC with ack -> pc=00000000. With PC_REDIRECT_STATS_EN, 3 taken branches -> stat_br_taken=3.
